iic_read: RTL and testbench
===========================

# iic_read

Register-read master for the camera SCCB/I2C port, the read-side counterpart of the sensor configuration writer. On a start pulse it performs a 16-bit-address random read: START, device-write address, register address high/low, repeated START, device-read address, one data byte, master NACK, STOP. It returns the byte or a NACK flag. It sits beside the configuration writer on the same `iic_sclk_o`/`iic_sda` pins; only one of the two is active at a time, selected by the config controller. It is used for sensor ID checks and read-back of configured registers.

## Interface
- `QTR_DIV`, default 300: camera_clk_i cycles per quarter bit; bit period = 4*QTR_DIV (1200 = 20 kHz at 24 MHz); legal ≥ 2
- `DEV_ADDR`, default 8'h78: 8-bit write address; read address = DEV_ADDR | 1
- `camera_clk_i`  in  1  system clock; all logic on posedge
- `iic_rstn_i`  in  1  reset; asynchronous, active-low
- `rd_start_i`  in  1  request; sampled when idle
- `rd_addr_i`  in  16  register address; latched on accept
- `rd_busy_o`  out  1  high from accept to done
- `rd_done_o`  out  1  one-cycle completion pulse
- `rd_data_o`  out  8  last successfully read byte
- `rd_nack_o`  out  1  last transaction aborted on slave NACK
- `iic_sclk_o`  out  1  SCL, push-pull
- `iic_sda`  inout  1  SDA, open-drain: drives 0 or z; external pull-up

## Operation
- Reset values:
  - `iic_sclk_o`=1, `iic_sda`=z
  - `rd_busy_o`=0, `rd_done_o`=0
  - `rd_data_o`=8'h00, `rd_nack_o`=0
  - FSM in IDLE, quarter counter=0
- IDLE: SCL=1, SDA released.
  - `rd_start_i`=1 → latch `rd_addr_i`, busy=1, clear `rd_nack_o`, enter START.
  - `rd_start_i` is ignored while busy; level-held start re-triggers only after done.
- Every bus state is a slot of 4 phases (ph0..ph3), each phase QTR_DIV cycles.
- Slot types:
  - START: SDA 1,1,0,0; SCL 1,1,1,0
  - BIT (TX/RX/ACK): SCL 0,1,1,0
    - TX: SDA set in ph0, held through ph3.
    - RX/ACK: SDA released; sampled on the first cycle of ph2.
  - RSTART: SDA z,z,0,0; SCL 0,1,1,0
  - STOP: SDA 0,0,z,z; SCL 0,1,1,1
- FSM: IDLE → START → TX → TACK → … → RSTART → TX → TACK → RX → MNACK → STOP → IDLE.
- TX/TACK covers 4 bytes, in order:
  - `DEV_ADDR`
  - addr[15:8]
  - addr[7:0]
  - DEV_ADDR|1 (sent after RSTART)
- Bit order: MSB first; 3-bit bit counter, byte index 0..3.
- TACK: sampled SDA=1 → NACK.
  - Set `rd_nack_o`=1 and go directly to STOP.
  - `rd_data_o` is unchanged.
- RX: 8 bits shifted in MSB first. MNACK: master releases SDA (NACK).
- `rd_data_o` is loaded at the end of MNACK.
- On STOP end: busy=0, `rd_done_o`=1 for one cycle, return to IDLE.
- `rd_nack_o` holds until the next accept.
- Reset mid-transfer: the bus returns to idle levels immediately (async). No STOP is generated; the slave recovers on the next START.

## Timing
- Accept: the edge sampling `rd_start_i`=1 in IDLE; `rd_busy_o` is high from the next cycle.
- Full read = 48 slots:
  - START: 1
  - 3 bytes × 9: 27
  - RSTART: 1
  - device-read address: 9
  - data + MNACK: 9
  - STOP: 1
- `rd_done_o` asserts 48*4*QTR_DIV cycles after the first cycle of START (accept + 1). In the same cycle, `rd_busy_o` drops and `rd_data_o`/`rd_nack_o` are final.
- Aborted reads:
  - NACK on byte k (k=0..3): slots = 1 + 9*(k+1) + STOP, plus 1 extra RSTART slot when k=3.
  - Device-address NACK: 11 slots.
- Earliest next accept is the cycle after `rd_done_o`. Back-to-back reads have one idle cycle between STOP and START.
- Changes of `rd_addr_i` after accept have no effect.

## Test plan
- Full read, QTR_DIV=4, bench slave ACKs all and returns 8'h56 at 0x300A → bytes on bus 78,30,0A, RSTART, 79. Master NACK, then STOP. `rd_data_o`=8'h56, `rd_nack_o`=0, done 768 cycles after START begins.
- Slave NACKs the device address → no further bytes, STOP follows. `rd_nack_o`=1, `rd_data_o` keeps its prior value, done after 11 slots (176 cycles).
- Slave NACKs addr[7:0] → `rd_nack_o`=1, done after 29 slots (464 cycles), no RSTART seen.
- `rd_start_i` pulsed mid-transfer, with `rd_addr_i` changed → ignored. The bus carries the original address; exactly one done pulse.
- `iic_rstn_i` low in RX byte 3 → SCL=1 and SDA=z in the same cycle; busy=0, outputs at reset values. A new start then performs a correct full read.
- `rd_start_i` held high for 2 reads (0x300A→8'h56, 0x300B→8'h40) → two done pulses. `rd_data_o` ends at 8'h40, with one idle cycle between STOP and START.

Source files
------------

// File: rtl/iic_read.sv
// iic_read: SCCB/I2C master for a 16-bit-address random read that returns one byte or a NACK flag
module iic_read #(
  parameter int         QTR_DIV  = 300,
  parameter logic [7:0] DEV_ADDR = 8'h78
) (
  input  logic        camera_clk_i,
  input  logic        iic_rstn_i,
  input  logic        rd_start_i,
  input  logic [15:0] rd_addr_i,
  output logic        rd_busy_o,
  output logic        rd_done_o,
  output logic [7:0]  rd_data_o,
  output logic        rd_nack_o,
  output logic        iic_sclk_o,
  inout  wire         iic_sda
);
  localparam int QW = $clog2(QTR_DIV);
  localparam logic [QW-1:0] QMAX = QW'(QTR_DIV - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_TX, S_TACK, S_RSTART, S_RX, S_MNACK, S_STOP} state_t;
  state_t      r_state, w_state_n;
  logic [QW-1:0] r_qcnt;
  logic [1:0]  r_ph, r_byte;
  logic [2:0]  r_bit;
  logic [15:0] r_addr;
  logic [7:0]  r_rx, r_data, w_tx_byte;
  logic        r_ack_s, r_busy, r_done, r_nack;
  logic        w_slot_end, w_sample, w_scl, w_sda_oe;
  always_comb begin
    w_slot_end = r_ph == 2'd3 && r_qcnt == QMAX;
    w_sample   = r_ph == 2'd2 && r_qcnt == '0;
    w_tx_byte  = r_byte == 2'd0 ? DEV_ADDR : r_byte == 2'd1 ? r_addr[15:8] :
                 r_byte == 2'd2 ? r_addr[7:0] : DEV_ADDR | 8'h01;
    w_state_n  = r_state;
    case (r_state)
      S_IDLE:   w_state_n = rd_start_i ? S_START : S_IDLE;
      S_START:  w_state_n = w_slot_end ? S_TX : S_START;
      S_TX:     w_state_n = w_slot_end && r_bit == 3'd0 ? S_TACK : S_TX;
      S_TACK:   w_state_n = !w_slot_end ? S_TACK : r_ack_s ? S_STOP : r_byte == 2'd3 ? S_RX :
                            r_byte == 2'd2 ? S_RSTART : S_TX;
      S_RSTART: w_state_n = w_slot_end ? S_TX : S_RSTART;
      S_RX:     w_state_n = w_slot_end && r_bit == 3'd0 ? S_MNACK : S_RX;
      S_MNACK:  w_state_n = w_slot_end ? S_STOP : S_MNACK;
      S_STOP:   w_state_n = w_slot_end ? S_IDLE : S_STOP;
      default:  w_state_n = S_IDLE;
    endcase
    // SCL/SDA are decoded straight from state so an async reset frees the bus at once
    w_scl    = r_state == S_IDLE ? 1'b1 : r_state == S_START ? r_ph != 2'd3 :
               r_state == S_STOP ? r_ph != 2'd0 : r_ph == 2'd1 || r_ph == 2'd2;
    w_sda_oe = (r_state == S_START || r_state == S_RSTART) ? r_ph[1] :
               r_state == S_STOP ? ~r_ph[1] : r_state == S_TX ? ~w_tx_byte[r_bit] : 1'b0;
  end
  always_ff @(posedge camera_clk_i or negedge iic_rstn_i) begin
    if (!iic_rstn_i) begin
      r_state <= S_IDLE;
      r_qcnt  <= '0;
      r_ph    <= '0;
      r_bit   <= 3'd7;
      r_byte  <= '0;
      r_addr  <= '0;
      r_rx    <= '0;
      r_ack_s <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
      r_nack  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_done  <= 1'b0;
      if (r_state == S_IDLE) begin
        r_qcnt <= '0;
        r_ph   <= '0;
        if (rd_start_i) begin
          r_addr <= rd_addr_i;
          r_busy <= 1'b1;
          r_nack <= 1'b0;
          r_byte <= '0;
          r_bit  <= 3'd7;
        end
      end else begin
        r_qcnt <= r_qcnt == QMAX ? '0 : r_qcnt + 1'b1;
        if (r_qcnt == QMAX) r_ph <= r_ph + 1'b1;
        if (w_sample && r_state == S_TACK) r_ack_s <= iic_sda;
        if (w_sample && r_state == S_RX) r_rx <= {r_rx[6:0], iic_sda};
        if (w_slot_end) begin
          r_bit <= (r_state == S_TX || r_state == S_RX) ? r_bit - 1'b1 : 3'd7;
          if (r_state == S_TACK && r_ack_s) r_nack <= 1'b1;
          if (r_state == S_TACK && !r_ack_s && r_byte != 2'd3) r_byte <= r_byte + 1'b1;
          if (r_state == S_MNACK) r_data <= r_rx;
          if (r_state == S_STOP) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end
      end
    end
  end
  assign iic_sclk_o = w_scl;
  assign iic_sda    = w_sda_oe ? 1'b0 : 1'bz;
  assign rd_busy_o  = r_busy;
  assign rd_done_o  = r_done;
  assign rd_data_o  = r_data;
  assign rd_nack_o  = r_nack;
endmodule

// File: tb/tb_iic_read.sv
// tb_iic_read: table-driven reads against a behavioural SCCB slave with a done-pulse scoreboard
module tb_iic_read;
  localparam int Q = 4;
  localparam int LOG_S = 256;
  localparam int LOG_P = 512;
  typedef struct {
    logic [15:0] addr;
    int          nack_at;
    logic [7:0]  data;
    logic        nack;
    int          slots;
  } vec_t;
  logic        clk = 1'b0, rstn = 1'b0, rd_start = 1'b0;
  logic [15:0] rd_addr = '0;
  logic        rd_busy, rd_done, rd_nack, scl;
  logic [7:0]  rd_data;
  wire         sda;
  pullup (sda);
  iic_read #(.QTR_DIV(Q), .DEV_ADDR(8'h78)) dut (
    .camera_clk_i(clk), .iic_rstn_i(rstn), .rd_start_i(rd_start), .rd_addr_i(rd_addr),
    .rd_busy_o(rd_busy), .rd_done_o(rd_done), .rd_data_o(rd_data), .rd_nack_o(rd_nack),
    .iic_sclk_o(scl), .iic_sda(sda)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] mem(input logic [15:0] a);
    return a == 16'h300A ? 8'h56 : a == 16'h300B ? 8'h40 : a[15:8] ^ a[7:0];
  endfunction
  // behavioural slave: records master-written bytes and START/STOP, ACKs except byte nack_at
  logic s_oe = 1'b0, p_scl = 1'b1, p_sda = 1'b1, s_first = 1'b0, s_rd = 1'b0, s_go_rd = 1'b0;
  logic [7:0] s_sh = '0, s_tx = '0;
  logic [15:0] s_reg = '0;
  int s_pos = 0, s_k = 0, nack_at = -1;
  int bus_log[$];
  assign sda = s_oe ? 1'b0 : 1'bz;
  always @(negedge clk) begin
    if (!rstn) begin
      s_oe = 1'b0; s_pos = 0; s_k = 0; s_rd = 1'b0; s_first = 1'b0; s_go_rd = 1'b0;
    end else if (p_scl && scl && p_sda && !sda) begin
      bus_log.push_back(LOG_S); s_pos = 0; s_first = 1'b1; s_rd = 1'b0;
    end else if (p_scl && scl && !p_sda && sda) begin
      bus_log.push_back(LOG_P); s_pos = 0; s_k = 0; s_rd = 1'b0; s_oe = 1'b0;
    end else if (!p_scl && scl) begin
      if (s_pos < 8) begin
        s_sh = {s_sh[6:0], sda};
        s_pos++;
        if (s_pos == 8 && !s_rd) begin
          bus_log.push_back(int'(s_sh));
          if (s_k == 1) s_reg[15:8] = s_sh;
          if (s_k == 2) s_reg[7:0] = s_sh;
        end
      end else if (s_pos == 8) s_pos = 9;
    end else if (p_scl && !scl) begin
      if (s_pos == 8) begin
        s_oe = !s_rd && s_k != nack_at;
        s_go_rd = !s_rd && s_first && s_sh[0] && s_oe;
        if (!s_rd) s_k++;
        s_first = 1'b0;
      end else if (s_pos == 9) begin
        s_pos = 0;
        s_oe = 1'b0;
        s_rd = 1'b0;
        if (s_go_rd) begin
          s_rd = 1'b1; s_go_rd = 1'b0; s_tx = mem(s_reg); s_oe = !s_tx[7];
        end
      end else if (s_rd && s_pos >= 1 && s_pos <= 7) s_oe = !s_tx[7 - s_pos];
    end
    p_scl = scl;
    p_sda = sda;
  end
  // scoreboard: one expectation per accepted read, consumed on each done pulse
  vec_t exp_q[$];
  int cyc = 0, t_busy = 0, n_done = 0;
  logic p_busy = 1'b0;
  always @(negedge clk) begin
    vec_t e;
    int el[$];
    int bad;
    cyc++;
    if (rd_busy && !p_busy) t_busy = cyc;
    p_busy = rd_busy;
    if (rd_done) begin
      n_done++;
      if (exp_q.size() == 0) chk("unexpected_done", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        chk("data", 32'(rd_data), 32'(e.data));
        chk("nack", 32'(rd_nack), 32'(e.nack));
        chk("busy_at_done", 32'(rd_busy), 32'd0);
        chk("cycles", cyc - t_busy, e.slots * 4 * Q);
        el = {LOG_S, 32'h78};
        if (e.nack_at != 0) el.push_back(int'(e.addr[15:8]));
        if (e.nack_at != 0 && e.nack_at != 1) el.push_back(int'(e.addr[7:0]));
        if (e.nack_at == -1 || e.nack_at == 3) begin
          el.push_back(LOG_S);
          el.push_back(32'h79);
        end
        el.push_back(LOG_P);
        bad = bus_log.size() == el.size() ? -1 : el.size();
        for (int i = 0; i < el.size() && i < bus_log.size(); i++)
          if (bad == -1 && bus_log[i] != el[i]) bad = i;
        chk("buslog_first_bad_index", bad, -1);
      end
      bus_log.delete();
    end
  end
  task automatic wait_done(input int target);
    int n = 0;
    while (n_done < target && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    if (n_done < target) chk("done_timeout", n_done, target);
  endtask
  task automatic start_read(input logic [15:0] a);
    @(posedge clk); #1;
    rd_start = 1'b1; rd_addr = a;
    @(posedge clk); #1;
    rd_start = 1'b0;
  endtask
  vec_t vecs[10];
  initial begin
    bit found;
    int n;
    vecs[0] = '{16'h300A, -1, 8'h56, 1'b0, 48};
    vecs[1] = '{16'h1234,  0, 8'h56, 1'b1, 11};
    vecs[2] = '{16'h300B,  2, 8'h56, 1'b1, 29};
    vecs[3] = '{16'h300B,  1, 8'h56, 1'b1, 20};
    vecs[4] = '{16'h300B,  3, 8'h56, 1'b1, 39};
    vecs[5] = '{16'h300B, -1, 8'h40, 1'b0, 48};
    vecs[6] = '{16'hABCD, -1, 8'h66, 1'b0, 48};
    vecs[7] = '{16'h00FF, -1, 8'hFF, 1'b0, 48};
    vecs[8] = '{16'h5555, -1, 8'h00, 1'b0, 48};
    vecs[9] = '{16'h300A, -1, 8'h56, 1'b0, 48};
    #23;
    chk("rst_scl", 32'(scl), 32'd1);
    chk("rst_sda", 32'(sda), 32'd1);
    chk("rst_busy", 32'(rd_busy), 32'd0);
    chk("rst_done", 32'(rd_done), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_nack", 32'(rd_nack), 32'd0);
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      nack_at = vecs[i].nack_at;
      exp_q.push_back(vecs[i]);
      start_read(vecs[i].addr);
      wait_done(i + 1);
    end
    // start pulse with a new address mid-transfer must be ignored
    nack_at = -1;
    exp_q.push_back('{16'h300A, -1, 8'h56, 1'b0, 48});
    start_read(16'h300A);
    repeat (300) @(posedge clk);
    start_read(16'h1111);
    wait_done(11);
    repeat (40) @(negedge clk);
    #1;
    chk("no_retrigger_busy", 32'(rd_busy), 32'd0);
    chk("single_done", n_done, 11);
    // async reset while the slave is returning the data byte
    exp_q.push_back('{16'h300B, -1, 8'h40, 1'b0, 48});
    start_read(16'h300B);
    found = 1'b0;
    n = 0;
    while (!found && n < 2000) begin
      @(negedge clk); #1;
      found = s_rd && !s_oe && !scl;
      n++;
    end
    chk("reached_rx", 32'(found), 32'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_scl", 32'(scl), 32'd1);
    chk("mid_rst_sda", 32'(sda), 32'd1);
    chk("mid_rst_busy", 32'(rd_busy), 32'd0);
    chk("mid_rst_done", 32'(rd_done), 32'd0);
    chk("mid_rst_data", 32'(rd_data), 32'd0);
    chk("mid_rst_nack", 32'(rd_nack), 32'd0);
    exp_q.delete();
    bus_log.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    exp_q.push_back('{16'h300A, -1, 8'h56, 1'b0, 48});
    start_read(16'h300A);
    wait_done(12);
    // level-held start: two back-to-back reads with one idle cycle between them
    exp_q.push_back('{16'h300A, -1, 8'h56, 1'b0, 48});
    exp_q.push_back('{16'h300B, -1, 8'h40, 1'b0, 48});
    @(posedge clk); #1;
    rd_start = 1'b1; rd_addr = 16'h300A;
    n = 0;
    while (!rd_busy && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("held_busy", 32'(rd_busy), 32'd1);
    rd_addr = 16'h300B;
    wait_done(13);
    chk("gap_busy_low", 32'(rd_busy), 32'd0);
    @(negedge clk); #1;
    chk("gap_busy_high", 32'(rd_busy), 32'd1);
    rd_start = 1'b0;
    wait_done(14);
    repeat (40) @(negedge clk);
    #1;
    chk("held_end_data", 32'(rd_data), 32'h40);
    chk("held_end_busy", 32'(rd_busy), 32'd0);
    chk("total_done", n_done, 14);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
